// File: rtl/fpu_mul_arb.sv
// Round-robin arbiter that shares one single-precision multiplier among NREQ requesters,
// with a watchdog that resets a stuck multiplier and answers with a canonical quiet NaN.
module fpu_mul_arb #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 128
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [31:0]          rsp_data,
   output logic                 rsp_err,
   output logic                 busy,
   output logic [31:0]          mul_din1,
   output logic [31:0]          mul_din2,
   output logic                 mul_dval,
   input  logic [31:0]          mul_result,
   input  logic                 mul_rdy,
   output logic                 mul_rst_n
);

   localparam int              GW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int              WW       = $clog2(TIMEOUT) + 1;
   localparam logic [WW-1:0]   WDC_LAST = WW'(TIMEOUT - 1);
   localparam logic [WW-1:0]   WDC_ONE  = WW'(1);
   localparam logic [GW-1:0]   GNT_LAST = GW'(NREQ - 1);
   localparam logic [GW-1:0]   GNT_ONE  = GW'(1);
   localparam logic [31:0]     QNAN     = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   state_t          state_r;
   state_t          state_nx_s;
   logic [GW-1:0]   ptr_r;
   logic [GW-1:0]   gnt_r;
   logic [GW-1:0]   grant_s;
   logic            grant_vld_s;
   logic [NREQ-1:0] gnt_oh_s;
   logic [WW-1:0]   wdc_r;
   logic            flush_r;
   int              scan_s;

   // Round-robin scan of req_valid starting at ptr_r, wrapping modulo NREQ.
   always_comb begin
      grant_s     = '0;
      grant_vld_s = 1'b0;
      scan_s      = 0;
      for (int i = 0; i < NREQ; i++) begin
         scan_s = int'(ptr_r) + i;
         if (scan_s >= NREQ) begin
            scan_s = scan_s - NREQ;
         end else begin
            scan_s = scan_s;
         end
         if (!grant_vld_s && req_valid[scan_s[GW-1:0]]) begin
            grant_vld_s = 1'b1;
            grant_s     = scan_s[GW-1:0];
         end else begin
            grant_vld_s = grant_vld_s;
         end
      end
   end

   // Accept is offered only in IDLE and depends on req_valid and state alone.
   always_comb begin
      req_ready = '0;
      if (state_r == ST_IDLE && grant_vld_s) begin
         req_ready[grant_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // One-hot form of the recorded grant.
   always_comb begin
      gnt_oh_s        = '0;
      gnt_oh_s[gnt_r] = 1'b1;
   end

   // Next-state logic; mul_rdy wins over a watchdog expiry in the same cycle.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_vld_s) state_nx_s = ST_ISSUE;
            else             state_nx_s = ST_IDLE;
         end
         ST_ISSUE: state_nx_s = ST_WAIT;
         ST_WAIT: begin
            if (mul_rdy)                 state_nx_s = ST_RESP;
            else if (wdc_r == WDC_LAST)  state_nx_s = ST_FLUSH;
            else                         state_nx_s = ST_WAIT;
         end
         ST_FLUSH: begin
            if (wdc_r == WDC_ONE) state_nx_s = ST_RESP;
            else                  state_nx_s = ST_FLUSH;
         end
         ST_RESP: begin
            if (rsp_ready[gnt_r]) state_nx_s = ST_IDLE;
            else                  state_nx_s = ST_RESP;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_nx_s;
   end

   // Operand capture, watchdog counter, response registers and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_din1  <= 32'h0000_0000;
         mul_din2  <= 32'h0000_0000;
         mul_dval  <= 1'b0;
         busy      <= 1'b0;
         flush_r   <= 1'b0;
         rsp_valid <= '0;
         rsp_data  <= 32'h0000_0000;
         rsp_err   <= 1'b0;
         ptr_r     <= '0;
         gnt_r     <= '0;
         wdc_r     <= '0;
      end else begin
         mul_dval <= (state_nx_s == ST_ISSUE);
         busy     <= (state_nx_s != ST_IDLE);
         flush_r  <= (state_nx_s == ST_FLUSH);
         case (state_r)
            ST_IDLE: begin
               if (grant_vld_s) begin
                  mul_din1 <= req_a[32*grant_s +: 32];
                  mul_din2 <= req_b[32*grant_s +: 32];
                  gnt_r    <= grant_s;
               end
            end
            ST_ISSUE: wdc_r <= '0;
            ST_WAIT: begin
               if (mul_rdy) begin
                  rsp_data  <= mul_result;
                  rsp_err   <= 1'b0;
                  rsp_valid <= gnt_oh_s;
               end else if (wdc_r == WDC_LAST) begin
                  rsp_data <= QNAN;
                  rsp_err  <= 1'b1;
                  wdc_r    <= '0;
               end else begin
                  wdc_r <= wdc_r + WDC_ONE;
               end
            end
            // The watchdog counter is reused to time the two-cycle multiplier reset.
            ST_FLUSH: begin
               if (wdc_r == WDC_ONE) rsp_valid <= gnt_oh_s;
               else                  wdc_r     <= wdc_r + WDC_ONE;
            end
            ST_RESP: begin
               if (rsp_ready[gnt_r]) begin
                  rsp_valid <= '0;
                  ptr_r     <= (gnt_r == GNT_LAST) ? '0 : gnt_r + GNT_ONE;
               end
            end
            default: begin
               rsp_valid <= '0;
            end
         endcase
      end
   end

   assign mul_rst_n = rst_n & ~flush_r;

endmodule

// File: doc/fpu_mul_arb.md
# fpu_mul_arb

Round-robin arbiter and sequencer that shares one single-precision multiplier (`fpu_sp_mul`) among `NREQ` requesters. It accepts one operand pair at a time and drives the multiplier's `din1`/`din2`/`dval`. It captures the result on `rdy` and returns it to the winning requester with a valid/ready handshake. A watchdog recovers from a multiplier that never completes by resetting it and returning a canonical NaN with an error flag.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 128: maximum cycles in WAIT before the watchdog fires, ≥ 64.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input NREQ: per-requester operand valid.
- `req_ready` output NREQ: one-hot accept, combinational.
- `req_a` input 32*NREQ: operand A; requester i uses bits [32i+31:32i].
- `req_b` input 32*NREQ: operand B, same packing as `req_a`.
- `rsp_valid` output NREQ: one-hot response valid, registered.
- `rsp_ready` input NREQ: per-requester response accept.
- `rsp_data` output 32: product, shared by all requesters.
- `rsp_err` output 1: 1 when the response was produced by watchdog timeout.
- `busy` output 1: high in every state except IDLE.
- `mul_din1` output 32, `mul_din2` output 32: operands to the multiplier, registered.
- `mul_dval` output 1: one-cycle start pulse.
- `mul_result` input 32: multiplier result.
- `mul_rdy` input 1: multiplier completion pulse.
- `mul_rst_n` output 1: multiplier reset = `rst_n` AND NOT (state==FLUSH).

## Operation
- **States:** IDLE, ISSUE, WAIT, FLUSH, RESP. Reset state is IDLE.
- **IDLE**
  - Scan `req_valid` starting at pointer `ptr`, wrapping modulo NREQ; the first set bit is grant `g`.
  - `req_ready[g]`=1, and only in IDLE.
  - On the transfer, latch `req_a[g]`/`req_b[g]` into `mul_din1`/`mul_din2`, record `g`, then go to ISSUE.
  - If no `req_valid` bit is set, stay in IDLE.
- **ISSUE:** `mul_dval`=1 for exactly this cycle. Clear the watchdog counter `wdc`. Go to WAIT.
- **WAIT**
  - `mul_din1`/`mul_din2` are held stable; `wdc` increments each cycle.
  - On `mul_rdy`=1: `rsp_data`<=`mul_result`, `rsp_err`<=0, go to RESP.
  - Else, if `wdc`==TIMEOUT-1: `rsp_data`<=32'h7FC00000, `rsp_err`<=1, go to FLUSH.
  - If both happen in the same cycle, `mul_rdy` wins.
- **FLUSH:** lasts 2 cycles, counted with `wdc` reused. `mul_rst_n`=0 for both cycles. Then go to RESP.
- **RESP**
  - `rsp_valid[g]`=1; `rsp_data`/`rsp_err` are held stable until `rsp_ready[g]`=1.
  - On the handshake: `ptr`<=(g+1) mod NREQ, clear `rsp_valid`, go to IDLE.
  - `rsp_ready` bits other than `g` are ignored.
- `mul_rdy` is ignored in every state except WAIT.
- **Fairness:** a requester granted once cannot win again until every other requester that is asserting `req_valid` has been served.
- **Reset values:** `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `mul_din1`=`mul_din2`=0, `mul_dval`=0, `busy`=0, `ptr`=0, `wdc`=0.
- **Reset mid-operation:** the arbiter returns to IDLE immediately, and the multiplier is reset through `mul_rst_n`. No response is issued for an in-flight request.

## Timing
- Request accepted at cycle T (IDLE); `mul_dval` is high at T+1; WAIT begins at T+2.
- `mul_rdy` sampled high at cycle X gives `rsp_valid` at X+1, which is the earliest possible.
- **Response handshake:** `rsp_ready` sampled at cycle Y puts the block back in IDLE at Y+1, where the next grant can occur. Minimum spacing between grants is 4 cycles plus the multiplier latency.
- **Timeout path:** WAIT lasts exactly TIMEOUT cycles, then FLUSH lasts 2 cycles, so `rsp_valid` rises TIMEOUT+2 cycles after WAIT entry.
- `req_ready` depends combinationally on `req_valid` and state only. It has no dependency on `rsp_ready`, so there is no combinational loop.
- The next `mul_dval` is at least 3 cycles after any `mul_rdy`, which keeps it clear of the multiplier's one-cycle `rdy` window.

## Test plan
- **Single request:** requester 1 sends a=0x40000000, b=0x40400000 (2.0 × 3.0) -> `rsp_valid[1]`, `rsp_data`=0x40C00000, `rsp_err`=0; `mul_dval` high for exactly 1 cycle.
- **All requesters at once:** all four `req_valid` asserted at once, each with a=0x3F800000 and b equal to the requester index cast to float -> grants in order 0, 1, 2, 3; each `rsp_data` equals its own b.
- **Fairness:** requester 0 keeps `req_valid` high continuously and requester 2 requests repeatedly -> grants alternate 0, 2, 0, 2.
- **Response back-pressure:** `rsp_ready` held low for 10 cycles -> `rsp_valid`, `rsp_data` and `busy` stay stable, and no `req_ready` is asserted.
- **Watchdog:** stub multiplier never asserts `mul_rdy` -> `rsp_data`=0x7FC00000 and `rsp_err`=1 arrive TIMEOUT+2 cycles after WAIT entry; `mul_rst_n` is low for exactly 2 cycles; the next request then completes normally.
- **Reset in WAIT:** `rst_n` pulsed low while in WAIT -> all outputs take their reset values asynchronously, `ptr`=0, and the first request after reset is served by requester 0 if it is asserting `req_valid`.
